syn_gpu_job_dispatch: RTL and testbench

SYN_GPU_JOB_DISPATCH -- requirements
Module: syn_gpu_job_dispatch

---
 rtl/syn_gpu_job_dispatch.sv | 199 +++++++++++++++++++
 tb/tb_syn_gpu_job_dispatch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_gpu_job_dispatch.sv
// rtl/syn_gpu_job_dispatch.sv - GPU job queue and draw-engine dispatcher behind a local-bus register file
//
// Purpose: jobs are assembled in a staging buffer (JOB_BFFR_1..7) and pushed into a FIFO by
// a JOB_BFFR_0 write carrying the target engine index. An FSM pops one job at a time, pulses
// the engine's start line, and waits for that engine's busy flag to rise and then fall.
// Optional feature: define SYN_GPU_JOB_TIMEOUT_EN to abort WAIT_DONE after 0xFFFF cycles
// and flag STATUS.timeout.
//
// Ports:
//   clk_ir, rst_sync_l        clock, synchronous active-low reset
//   lb_wr_en/lb_rd_en         local-bus strobes; lb_addr, lb_wr_data request fields
//   lb_wr_valid/lb_rd_valid   registered acks; lb_rd_data registered read data
//   eng_job_start             one-hot start pulse per engine
//   eng_job_data              job words 1..7 of the issued job
//   eng_busy                  per-engine busy flags
//   eng_sel, eng_sel_vld      engine owning the pixel path, and its qualifier
module syn_gpu_job_dispatch #(
  parameter int P_NUM_ENG    = 2,
  parameter int P_FIFO_DEPTH = 4
) (
  input  logic                 clk_ir,
  input  logic                 rst_sync_l,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [7:0]           lb_addr,
  input  logic [31:0]          lb_wr_data,
  output logic                 lb_wr_valid,
  output logic                 lb_rd_valid,
  output logic [31:0]          lb_rd_data,
  output logic [P_NUM_ENG-1:0] eng_job_start,
  output logic [111:0]         eng_job_data,
  input  logic [P_NUM_ENG-1:0] eng_busy,
  output logic [1:0]           eng_sel,
  output logic                 eng_sel_vld
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(P_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t         state_q, state_d;
  logic           gpu_en_q;
  logic [15:0]    stage_q [1:7];
  logic [113:0]   fifo_q [P_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;
  logic           ovf_q, bad_eng_q, rd_status_q;
  logic [1:0]     eng_q;
  logic [111:0]   job_data_q;
  logic           ack_cnt_q, ack_cnt_d;
  logic           wr_valid_q, rd_valid_q;
  logic [31:0]    rd_data_q;

  logic [111:0]   stage_flat;
  logic [3:0]     busy_ext;
  logic [113:0]   head;
  logic           empty, full, pop, wr_ctrl, flush, push_req, bad_push, do_push, ovf_set;
  logic           tmo_hit, tmo_flag;
  logic [31:0]    rd_mux;
  logic [15:0]    status;
  logic           unused_wr_hi;

  assign unused_wr_hi = ^lb_wr_data[31:16];

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  assign head     = fifo_q[rd_ptr_q];
  assign wr_ctrl  = lb_wr_en && (lb_addr == 8'h00);
  assign flush    = wr_ctrl && lb_wr_data[1];
  assign push_req = lb_wr_en && (lb_addr == 8'h08) && !flush;
  assign bad_push = push_req && ({30'd0, lb_wr_data[1:0]} >= 32'(P_NUM_ENG));
  // A pop on the same edge frees a slot, so a push into a full FIFO is still accepted.
  assign do_push  = push_req && !bad_push && (!full || pop);
  assign ovf_set  = push_req && !bad_push && full && !pop;

  always_comb begin
    busy_ext = '0;
    busy_ext[P_NUM_ENG-1:0] = eng_busy;
    stage_flat = '0;
    for (int k = 1; k < 8; k++) stage_flat[16*(k-1) +: 16] = stage_q[k];
  end

`ifdef SYN_GPU_JOB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        timeout_q;
  // The counter reaches 0xFFFF on the same edge the FSM leaves WAIT_DONE.
  assign tmo_hit  = (state_q == WAIT_DONE) && (tmo_cnt_q == 16'hFFFE);
  assign tmo_flag = timeout_q;
  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l || state_q != WAIT_DONE) tmo_cnt_q <= '0;
    else                                      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    if (!rst_sync_l) timeout_q <= 1'b0;
    else             timeout_q <= tmo_hit | (timeout_q & ~rd_status_q);
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_flag = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: if (gpu_en_q && !empty && !busy_ext[head[113:112]]) begin
        state_d = ISSUE;
        pop     = 1'b1;
      end
      ISSUE: begin
        state_d   = WAIT_ACK;
        ack_cnt_d = 1'b0;
      end
      // Give up waiting for busy after two cycles so zero-length jobs do not hang.
      WAIT_ACK: if (busy_ext[eng_q] || ack_cnt_q) state_d = WAIT_DONE;
                else                              ack_cnt_d = 1'b1;
      WAIT_DONE: if (!busy_ext[eng_q] || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign status = {busy_ext, 1'b0, tmo_flag, bad_eng_q, ovf_q, 5'(count_q), full, empty,
                   state_q != IDLE};

  always_comb begin
    rd_mux = 32'hDEADBABE;
    if (lb_addr == 8'h00)      rd_mux = {31'd0, gpu_en_q};
    else if (lb_addr == 8'h01) rd_mux = {16'd0, status};
    else if (lb_addr == 8'h08) rd_mux = '0;
    for (int k = 1; k < 8; k++)
      if (lb_addr == 8'(8 + k)) rd_mux = {16'd0, stage_q[k]};
  end

  always_ff @(posedge clk_ir) begin
    if (rst_sync_l && do_push) fifo_q[wr_ptr_q] <= {lb_wr_data[1:0], stage_flat};
  end

  always_ff @(posedge clk_ir) begin
    if (!rst_sync_l) begin
      state_q     <= IDLE;
      ack_cnt_q   <= 1'b0;
      gpu_en_q    <= 1'b0;
      for (int k = 1; k < 8; k++) stage_q[k] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      bad_eng_q   <= 1'b0;
      rd_status_q <= 1'b0;
      eng_q       <= '0;
      job_data_q  <= '0;
      wr_valid_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      if (wr_ctrl) gpu_en_q <= lb_wr_data[0];
      for (int k = 1; k < 8; k++)
        if (lb_wr_en && lb_addr == 8'(8 + k)) stage_q[k] <= lb_wr_data[15:0];
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({do_push, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
      if (pop) begin
        eng_q      <= head[113:112];
        job_data_q <= head[111:0];
      end
      // Sticky bits clear one cycle after the STATUS read ack; a new set event wins.
      rd_status_q <= lb_rd_en && (lb_addr == 8'h01);
      ovf_q       <= ovf_set  | (ovf_q & ~rd_status_q);
      bad_eng_q   <= bad_push | (bad_eng_q & ~rd_status_q);
      wr_valid_q  <= lb_wr_en;
      rd_valid_q  <= lb_rd_en;
      rd_data_q   <= lb_rd_en ? rd_mux : '0;
    end
  end

  always_comb begin
    eng_job_start = '0;
    for (int e = 0; e < P_NUM_ENG; e++)
      eng_job_start[e] = rst_sync_l && (state_q == ISSUE) && (eng_q == 2'(e));
  end

  assign lb_wr_valid  = rst_sync_l && wr_valid_q;
  assign lb_rd_valid  = rst_sync_l && rd_valid_q;
  assign lb_rd_data   = rst_sync_l ? rd_data_q : '0;
  assign eng_job_data = rst_sync_l ? job_data_q : '0;
  assign eng_sel      = rst_sync_l ? eng_q : '0;
  assign eng_sel_vld  = rst_sync_l && (state_q != IDLE);
endmodule

// File: tb/tb_syn_gpu_job_dispatch.sv
// tb/tb_syn_gpu_job_dispatch.sv - self-checking bench for syn_gpu_job_dispatch
module tb_syn_gpu_job_dispatch;
  logic         clk_ir = 1'b0;
  logic         rst_sync_l, lb_wr_en, lb_rd_en;
  logic [7:0]   lb_addr;
  logic [31:0]  lb_wr_data;
  logic         lb_wr_valid, lb_rd_valid;
  logic [31:0]  lb_rd_data;
  logic [1:0]   eng_job_start, eng_busy, eng_sel;
  logic [111:0] eng_job_data;
  logic         eng_sel_vld;

  int total = 0;
  int bad   = 0;

  always #5 clk_ir = ~clk_ir;

  syn_gpu_job_dispatch dut (
    .clk_ir(clk_ir), .rst_sync_l(rst_sync_l), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en),
    .lb_addr(lb_addr), .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid),
    .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data), .eng_job_start(eng_job_start),
    .eng_job_data(eng_job_data), .eng_busy(eng_busy), .eng_sel(eng_sel),
    .eng_sel_vld(eng_sel_vld)
  );

  typedef struct {
    logic [1:0]   st;
    logic [111:0] d;
  } start_t;
  start_t starts_q[$];

  always @(negedge clk_ir)
    if (rst_sync_l === 1'b1 && eng_job_start != 2'b00)
      starts_q.push_back('{st: eng_job_start, d: eng_job_data});

  // Engine responder: either a forced busy vector or random busy lengths after each start.
  logic       resp_en = 1'b0;
  logic [1:0] busy_force = 2'b00;
  logic [1:0] auto_busy = 2'b00;
  int         rem[2];
  assign eng_busy = resp_en ? auto_busy : busy_force;

  always @(posedge clk_ir) begin
    #1;
    for (int e = 0; e < 2; e++) begin
      if (!resp_en)               rem[e] = 0;
      else if (eng_job_start[e])  rem[e] = $urandom_range(0, 5);
      else if (rem[e] > 0)        rem[e] = rem[e] - 1;
      auto_busy[e] = (rem[e] > 0);
    end
  end

  logic [111:0] model_stage;

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(posedge clk_ir); #1;
    lb_wr_en = 1'b1; lb_addr = a; lb_wr_data = d;
    @(posedge clk_ir); #1;
    lb_wr_en = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d, output logic v);
    @(posedge clk_ir); #1;
    lb_rd_en = 1'b1; lb_addr = a;
    @(posedge clk_ir); #1;
    lb_rd_en = 1'b0;
    d = lb_rd_data; v = lb_rd_valid;
  endtask

  task automatic write_stage(input int k, input logic [31:0] v);
    bus_wr(8'(8 + k), v);
    model_stage[16*(k-1) +: 16] = v[15:0];
  endtask

  task automatic test_reset();
    logic [31:0] d; logic v;
    rst_sync_l = 1'b0; lb_wr_en = 1'b0; lb_rd_en = 1'b0; lb_addr = '0; lb_wr_data = '0;
    resp_en = 1'b0; busy_force = 2'b00; model_stage = '0;
    repeat (3) @(posedge clk_ir); #1;
    total++;
    if ({lb_wr_valid, lb_rd_valid, lb_rd_data, eng_job_start, eng_job_data, eng_sel, eng_sel_vld} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %h want 0",
        {lb_wr_valid, lb_rd_valid, lb_rd_data, eng_job_start, eng_job_data, eng_sel, eng_sel_vld});
    end
    rst_sync_l = 1'b1;
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h2 || v !== 1'b1) begin bad++; $display("FAIL reset_status: got %h/%b want 00000002/1", d, v); end
    bus_rd(8'h00, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_control: got %h want 0", d); end
    bus_wr(8'h40, 32'h1234);
    total++; if (lb_wr_valid !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", lb_wr_valid); end
    @(posedge clk_ir); #1;
    total++; if (lb_wr_valid !== 1'b0) begin bad++; $display("FAIL wr_ack_pulse: got %b want 0", lb_wr_valid); end
  endtask

  task automatic test_regs();
    logic [31:0] d, v32[1:7]; logic v; logic [7:0] a;
    for (int k = 1; k < 8; k++) begin v32[k] = $urandom; write_stage(k, v32[k]); end
    for (int k = 1; k < 8; k++) begin
      bus_rd(8'(8 + k), d, v);
      total++; if (d !== {16'd0, v32[k][15:0]}) begin bad++; $display("FAIL stage_rd%0d: got %h want %h", k, d, {16'd0, v32[k][15:0]}); end
    end
    for (int i = 0; i < 4; i++) begin
      a = (i < 2) ? 8'($urandom_range(2, 7)) : 8'($urandom_range(16, 255));
      bus_wr(a, $urandom);
      bus_rd(a, d, v);
      total++; if (d !== 32'hDEADBABE || v !== 1'b1) begin bad++; $display("FAIL unmapped_rd %h: got %h/%b want deadbabe/1", a, d, v); end
    end
  endtask

  task automatic test_single_issue();
    logic [31:0] d; logic v;
    resp_en = 1'b0; busy_force = 2'b00;
    for (int k = 1; k < 8; k++) write_stage(k, 32'(k));
    bus_wr(8'h00, 32'h1);
    starts_q.delete();
    @(posedge clk_ir); #1; lb_wr_en = 1'b1; lb_addr = 8'h08; lb_wr_data = 32'h0;
    @(posedge clk_ir); #1; lb_wr_en = 1'b0;
    total++; if (eng_job_start !== 2'b00) begin bad++; $display("FAIL issue_early: got %b want 00", eng_job_start); end
    @(posedge clk_ir); #1;
    total++; if (eng_job_start !== 2'b01) begin bad++; $display("FAIL issue_latency: got %b want 01", eng_job_start); end
    total++; if (eng_job_data[15:0] !== 16'h0001 || eng_job_data[111:96] !== 16'h0007 || eng_job_data !== model_stage) begin
      bad++; $display("FAIL issue_data: got %h want %h", eng_job_data, model_stage); end
    total++; if ({eng_sel_vld, eng_sel} !== 3'b100) begin bad++; $display("FAIL issue_sel: got %b want 100", {eng_sel_vld, eng_sel}); end
    @(posedge clk_ir); #1;
    total++; if (eng_job_start !== 2'b00) begin bad++; $display("FAIL issue_pulse: got %b want 00", eng_job_start); end
    repeat (8) @(posedge clk_ir);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL zero_len_done: got %h want 00000002", d); end
  endtask

  task automatic test_ovf();
    logic [31:0] d; logic v; int n; int fill;
    bus_wr(8'h00, 32'h0);
    n = $urandom_range(5, 7);
    fill = (n > 4) ? 4 : n;
    for (int j = 0; j < n; j++) bus_wr(8'h08, 32'h0);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'((fill << 3) | 4 | 256)) begin bad++; $display("FAIL ovf_status: got %h want %h", d, 32'((fill << 3) | 4 | 256)); end
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'((fill << 3) | 4)) begin bad++; $display("FAIL ovf_clear: got %h want %h", d, 32'((fill << 3) | 4)); end
    bus_wr(8'h00, 32'h2);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL flush_empty: got %h want 00000002", d); end
    bus_rd(8'h00, d, v);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL flush_rd0: got %h want 0", d); end
  endtask

  task automatic test_bad_eng();
    logic [31:0] d; logic v; logic [1:0] e;
    resp_en = 1'b0; busy_force = 2'b00;
    bus_wr(8'h00, 32'h1);
    starts_q.delete();
    e = 2'($urandom_range(2, 3));
    bus_wr(8'h08, {30'd0, e});
    repeat (10) @(posedge clk_ir);
    total++; if (starts_q.size() != 0) begin bad++; $display("FAIL bad_eng_start: got %0d starts want 0", starts_q.size()); end
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h202) begin bad++; $display("FAIL bad_eng_status: got %h want 00000202", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic v; logic [111:0] job[2]; int found; int sel_ok;
    resp_en = 1'b0; busy_force = 2'b00;
    bus_wr(8'h00, 32'h0);
    for (int j = 0; j < 2; j++) begin
      for (int k = 1; k < 8; k++) write_stage(k, $urandom);
      job[j] = model_stage;
      bus_wr(8'h08, 32'h1);
    end
    bus_wr(8'h00, 32'h1);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin @(posedge clk_ir); #1; if (eng_job_start != 2'b00) found = 1; end
    total++; if (eng_job_start !== 2'b10 || eng_job_data !== job[0]) begin bad++; $display("FAIL b2b_first: got %b %h want 10 %h", eng_job_start, eng_job_data, job[0]); end
    busy_force = 2'b10;
    sel_ok = 1;
    repeat (9) begin @(posedge clk_ir); #1; if (eng_job_start != 2'b00 || eng_sel != 2'd1 || eng_sel_vld != 1'b1) sel_ok = 0; end
    @(posedge clk_ir); #1; busy_force = 2'b00;
    total++; if (sel_ok != 1 || eng_sel_vld !== 1'b1 || eng_sel !== 2'd1) begin bad++; $display("FAIL b2b_hold: got ok=%0d vld=%b sel=%0d want 1 1 1", sel_ok, eng_sel_vld, eng_sel); end
    @(posedge clk_ir); #1;
    total++; if (eng_sel_vld !== 1'b0 || eng_job_start !== 2'b00) begin bad++; $display("FAIL b2b_idle_gap: got vld=%b start=%b want 0 00", eng_sel_vld, eng_job_start); end
    @(posedge clk_ir); #1;
    total++; if (eng_job_start !== 2'b10 || eng_job_data !== job[1] || eng_sel !== 2'd1) begin bad++; $display("FAIL b2b_second: got %b %h want 10 %h", eng_job_start, eng_job_data, job[1]); end
    busy_force = 2'b10;
    repeat (9) @(posedge clk_ir);
    #1; busy_force = 2'b00;
    repeat (5) @(posedge clk_ir);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL b2b_done: got %h want 00000002", d); end
  endtask

  task automatic test_random();
    logic [31:0] d; logic v; logic [1:0] e; logic [113:0] expq[$]; int n; int exp_bad;
    resp_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      expq.delete(); exp_bad = 0;
      bus_wr(8'h00, 32'h0);
      starts_q.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        for (int k = 1; k < 8; k++) write_stage(k, $urandom);
        e = 2'($urandom_range(0, 3));
        bus_wr(8'h08, {30'd0, e});
        if (e < 2) expq.push_back({e, model_stage}); else exp_bad = 1;
      end
      bus_wr(8'h00, 32'h1);
      repeat (120) @(posedge clk_ir);
      #1;
      total++; if (starts_q.size() != expq.size()) begin bad++; $display("FAIL rand_count r%0d: got %0d want %0d", r, starts_q.size(), expq.size()); end
      for (int j = 0; j < expq.size() && j < starts_q.size(); j++) begin
        total++;
        if (starts_q[j].st !== (2'b01 << expq[j][113:112]) || starts_q[j].d !== expq[j][111:0]) begin
          bad++; $display("FAIL rand_job r%0d j%0d: got %b %h want eng %0d %h", r, j, starts_q[j].st, starts_q[j].d, expq[j][113:112], expq[j][111:0]);
        end
      end
      bus_rd(8'h01, d, v);
      total++; if (d !== (32'h2 | (32'(exp_bad) << 9))) begin bad++; $display("FAIL rand_status r%0d: got %h want %h", r, d, 32'h2 | (32'(exp_bad) << 9)); end
    end
    resp_en = 1'b0;
    bus_wr(8'h00, 32'h0);
  endtask

  task automatic test_full_pushpop_flush();
    logic [31:0] d; logic v;
    resp_en = 1'b0; busy_force = 2'b00;
    bus_wr(8'h00, 32'h0);
    for (int j = 0; j < 4; j++) bus_wr(8'h08, 32'h0);
    starts_q.delete();
    bus_wr(8'h00, 32'h1);
    lb_wr_en = 1'b1; lb_addr = 8'h08; lb_wr_data = 32'h0;
    @(posedge clk_ir); #1; lb_wr_en = 1'b0;
    busy_force = 2'b01;
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h1025) begin bad++; $display("FAIL pushpop_full: got %h want 00001025", d); end
    bus_wr(8'h00, 32'h3);
    busy_force = 2'b00;
    repeat (10) @(posedge clk_ir);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL flush_status: got %h want 00000002", d); end
    total++; if (starts_q.size() != 1) begin bad++; $display("FAIL flush_starts: got %0d want 1", starts_q.size()); end
    bus_rd(8'h00, d, v);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL flush_ctrl: got %h want 00000001", d); end
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] d; logic v;
    resp_en = 1'b0; busy_force = 2'b01;
    bus_wr(8'h00, 32'h0);
    bus_wr(8'h08, 32'h0);
    busy_force = 2'b00;
    bus_wr(8'h00, 32'h1);
    @(posedge clk_ir); #1; busy_force = 2'b01;
    for (int j = 0; j < 3; j++) bus_wr(8'h08, 32'h0);
    bus_rd(8'h01, d, v);
    total++; if (d !== 32'(1 | (3 << 3) | (1 << 12))) begin bad++; $display("FAIL midjob_status: got %h want 00001019", d); end
    rst_sync_l = 1'b0;
    @(posedge clk_ir); #1;
    total++; if ({eng_job_start, eng_sel_vld, eng_sel, lb_rd_valid, eng_job_data} !== '0) begin bad++; $display("FAIL midjob_rst_out: got %h want 0", {eng_job_start, eng_sel_vld, eng_sel, lb_rd_valid, eng_job_data}); end
    @(posedge clk_ir); #1;
    rst_sync_l = 1'b1; model_stage = '0;
    starts_q.delete();
    bus_rd(8'h01, d, v);
    total++; if ((d & 32'hFFFF0FFF) !== 32'h2 || d[15:12] !== 4'h1) begin bad++; $display("FAIL midjob_post_status: got %h want 00001002", d); end
    busy_force = 2'b00;
    repeat (20) @(posedge clk_ir);
    total++; if (starts_q.size() != 0) begin bad++; $display("FAIL midjob_no_start: got %0d want 0", starts_q.size()); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_single_issue();
    test_ovf();
    test_bad_eng();
    test_back_to_back();
    test_random();
    test_full_pushpop_flush();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
